i2c_master: RTL and testbench
=============================

I2C_MASTER -- requirements
Module: i2c_master

Interface
REQ-001 Parameter CLK_DIV, default 20, clk cycles per SCL quarter-period; 8 MHz clk gives 100 kHz SCL.
REQ-002 Parameter DEV_ADDR, default 7'h10, 7-bit target device address.
REQ-003 clk  input  1  single system clock; every flop is on posedge clk.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req  input  1  one-cycle transaction request.
REQ-006 rd_nwr  input  1  1 = register read, 0 = register write; sampled with req.
REQ-007 reg_addr  input  8  target register address; sampled with req.
REQ-008 wdata  input  8  write data; sampled with req.
REQ-009 rdata  output  8  read data; valid from the done pulse until the next req.
REQ-010 busy  output  1  high from the cycle after an accepted req until done.
REQ-011 done  output  1  one-cycle pulse when a transaction ends.
REQ-012 err  output  1  NACK flag; valid with done, held until the next accepted req.
REQ-013 scl_in, sda_in  input  1 each  sampled bus levels.
REQ-014 scl_drv_lo, sda_drv_lo  output  1 each  open-drain pull-low enables; 0 releases the line.

Function
REQ-015 A tick counter shall divide clk by CLK_DIV, so each SCL bit period is four phases (P0-P3); SCL is low in P0-P1 and released in P2-P3.
REQ-016 SDA shall change only in P0, and be sampled at the end of P2.
REQ-017 req shall be accepted only in IDLE; req while busy shall be ignored with no state change.
REQ-018 States: IDLE, START, ADDR_W, ACK1, REG, ACK2, WDATA, ACK3, RSTART, ADDR_R, ACK4, RDATA, MNACK, STOP.
REQ-019 Write sequence: START, {DEV_ADDR,0}, ACK, reg_addr, ACK, wdata, ACK, STOP.
REQ-020 Read sequence: START, {DEV_ADDR,0}, ACK, reg_addr, ACK, repeated START, {DEV_ADDR,1}, ACK, 8 data bits MSB first, master NACK (SDA released), STOP.
REQ-021 START and repeated START: SDA is pulled low while SCL is released, then SCL is pulled low one quarter-period later.
REQ-022 STOP: SDA is held low while SCL is released, then SDA is released one quarter-period later.
REQ-023 Any ACK bit sampled high shall set err, skip the remaining bytes, and go to STOP.
REQ-024 done shall pulse exactly once, in the cycle STOP completes; the state returns to IDLE that cycle and busy deasserts.
REQ-025 Bytes shall go out MSB first; a 3-bit bit counter wraps 7->0 at each byte boundary.
REQ-026 rdata shall be updated only on a read that completes without error; on error it keeps its previous value.
REQ-027 In IDLE both drive outputs shall be 0 (bus released).

Reset
REQ-028 Assertion of reset_n (low) shall asynchronously force: state IDLE, scl_drv_lo=0, sda_drv_lo=0, busy=0, done=0, err=0, rdata=8'h00, and all counters to 0.
REQ-029 Reset mid-transaction shall abandon the transaction with no STOP and no done pulse.

Configuration
REQ-030 With I2C_MST_STRETCH_EN defined, the tick counter shall hold in P2/P3 while scl_in is sampled low after SCL is released (clock stretching support).
REQ-031 Without I2C_MST_STRETCH_EN, scl_in shall be ignored and timing shall be purely tick-driven.

Structure
REQ-032 A shared package i2c_pkg shall hold the state enum typedef, the phase enum, and the constants I2C_RD=1'b1 and I2C_WR=1'b0.
REQ-033 The quarter-period tick generator shall be a sub-module, i2c_tick_gen, with enable and hold inputs.

Verification
REQ-034 Write reg 8'h01, data 8'h05, slave model ACKs every byte -> bus bytes 8'h20, 8'h01, 8'h05, then STOP; done pulses once; err=0.
REQ-035 Read reg 8'h00, slave model returns 8'h10 -> bus bytes 8'h20, 8'h00, repeated START, 8'h21; master NACKs the data byte; rdata=8'h10; err=0.
REQ-036 Slave model NACKs the address byte -> err=1, STOP follows directly, done pulses, rdata is unchanged.
REQ-037 req pulsed again during the REG state -> ignored; exactly one transaction appears on the bus.
REQ-038 reset_n pulled low during WDATA bit 3 -> both drive outputs 0 in the same cycle, busy=0, no done pulse.
REQ-039 With I2C_MST_STRETCH_EN defined, slave holds SCL low for 5 quarter-periods after the ACK2 release -> the high phase is extended by 5 quarter-periods and the data is unchanged.

Source files
------------

// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C register-access master.
package i2c_pkg;

    localparam logic I2C_RD = 1'b1;
    localparam logic I2C_WR = 1'b0;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_START,
        ST_ADDR_W,
        ST_ACK1,
        ST_REG,
        ST_ACK2,
        ST_WDATA,
        ST_ACK3,
        ST_RSTART,
        ST_ADDR_R,
        ST_ACK4,
        ST_RDATA,
        ST_MNACK,
        ST_STOP
    } state_t;

    // Quarter-period phases of one SCL bit: SCL low in P0/P1, released in P2/P3.
    typedef enum logic [1:0] {
        PH_0,
        PH_1,
        PH_2,
        PH_3
    } phase_t;

    // Master-driven byte slots: SDA carries the shift-register MSB.
    function automatic logic is_tx_byte(input state_t s);
        return (s == ST_ADDR_W) || (s == ST_REG) || (s == ST_WDATA) || (s == ST_ADDR_R);
    endfunction

endpackage

// File: rtl/i2c_tick_gen.sv
// Quarter-period tick generator: down-counter reloaded with CLK_DIV-1,
// tick on terminal count. hold freezes the count (used for clock stretching).
module i2c_tick_gen #(
    parameter int CLK_DIV = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic enable,
    input  logic hold,
    output logic tick
);

    localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
    localparam logic [CW-1:0] RELOAD = CW'(CLK_DIV - 1);

    logic [CW-1:0] cnt;

    assign tick = enable && !hold && (cnt == '0);

    // Preload while disabled so the first quarter after enable is full length.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt <= '0;
        end else if (!enable) begin
            cnt <= RELOAD;
        end else if (hold) begin
            cnt <= cnt;
        end else if (cnt == '0) begin
            cnt <= RELOAD;
        end else begin
            cnt <= cnt - 1'b1;
        end
    end

endmodule

// File: rtl/i2c_master.sv
// I2C register-access master: single-byte register write, or register read
// via repeated START. Open-drain outputs are registered pull-low enables.
// Optional build macro: I2C_MST_STRETCH_EN (honour slave clock stretching).
//
// state     | meaning
// ----------+-----------------------------------------------
// IDLE      | bus released, waiting for req
// START     | SDA falls while SCL released
// ADDR_W    | device address + write bit
// ACK1      | slave ACK of ADDR_W
// REG       | register address byte
// ACK2      | slave ACK of REG
// WDATA     | write data byte
// ACK3      | slave ACK of WDATA
// RSTART    | repeated START before read address
// ADDR_R    | device address + read bit
// ACK4      | slave ACK of ADDR_R
// RDATA     | 8 data bits from slave, MSB first
// MNACK     | master NACK (SDA released) ends the read
// STOP      | SDA rises while SCL released, then done
module i2c_master
    import i2c_pkg::*;
#(
    parameter int         CLK_DIV  = 20,
    parameter logic [6:0] DEV_ADDR = 7'h10
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       req,
    input  logic       rd_nwr,
    input  logic [7:0] reg_addr,
    input  logic [7:0] wdata,
    output logic [7:0] rdata,
    output logic       busy,
    output logic       done,
    output logic       err,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_drv_lo,
    output logic       sda_drv_lo
);

    state_t     state;
    phase_t     phase;
    logic [2:0] bit_cnt;
    logic [7:0] shreg;
    logic       samp;
    logic       rd_q;
    logic [7:0] reg_q;
    logic [7:0] wdata_q;
    logic       tick;
    logic       hold;
    logic       tick_en;
    logic       low_half;
    logic       scl_lo_nxt;
    logic       sda_lo_nxt;

    assign tick_en  = (state != ST_IDLE);
    assign low_half = (phase == PH_0) || (phase == PH_1);

`ifdef I2C_MST_STRETCH_EN
    // Only treat SCL as stretched once our own pull-low has been released.
    assign hold = ((phase == PH_2) || (phase == PH_3)) && !scl_drv_lo && !scl_in;
`else
    logic scl_in_unused;
    assign scl_in_unused = scl_in;
    assign hold = 1'b0;
`endif

    i2c_tick_gen #(
        .CLK_DIV(CLK_DIV)
    ) u_tick_gen (
        .clk    (clk),
        .reset_n(reset_n),
        .enable (tick_en),
        .hold   (hold),
        .tick   (tick)
    );

    // Sequencer: accepts req in IDLE, advances phase on each tick, moves state at end of P3.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= ST_IDLE;
            phase   <= PH_0;
            bit_cnt <= 3'd0;
            shreg   <= 8'h00;
            samp    <= 1'b0;
            rd_q    <= 1'b0;
            reg_q   <= 8'h00;
            wdata_q <= 8'h00;
            rdata   <= 8'h00;
            busy    <= 1'b0;
            done    <= 1'b0;
            err     <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == ST_IDLE) begin
                if (req) begin
                    rd_q    <= rd_nwr;
                    reg_q   <= reg_addr;
                    wdata_q <= wdata;
                    err     <= 1'b0;
                    busy    <= 1'b1;
                    phase   <= PH_0;
                    bit_cnt <= 3'd0;
                    state   <= ST_START;
                end
            end else if (tick) begin
                phase <= phase_t'(phase + 2'd1);
                if (phase == PH_2) begin
                    samp <= sda_in;
                    if (state == ST_RDATA) begin
                        shreg <= {shreg[6:0], sda_in};
                    end
                end
                if (phase == PH_3) begin
                    if (is_tx_byte(state)) begin
                        bit_cnt <= bit_cnt + 3'd1;
                        shreg   <= {shreg[6:0], 1'b0};
                    end
                    case (state)
                        ST_START: begin
                            shreg <= {DEV_ADDR, I2C_WR};
                            state <= ST_ADDR_W;
                        end
                        ST_ADDR_W: if (bit_cnt == 3'd7) state <= ST_ACK1;
                        ST_REG:    if (bit_cnt == 3'd7) state <= ST_ACK2;
                        ST_WDATA:  if (bit_cnt == 3'd7) state <= ST_ACK3;
                        ST_ADDR_R: if (bit_cnt == 3'd7) state <= ST_ACK4;
                        ST_ACK1: begin
                            if (samp) begin
                                err   <= 1'b1;
                                state <= ST_STOP;
                            end else begin
                                shreg <= reg_q;
                                state <= ST_REG;
                            end
                        end
                        ST_ACK2: begin
                            if (samp) begin
                                err   <= 1'b1;
                                state <= ST_STOP;
                            end else if (rd_q == I2C_RD) begin
                                state <= ST_RSTART;
                            end else begin
                                shreg <= wdata_q;
                                state <= ST_WDATA;
                            end
                        end
                        ST_ACK3: begin
                            err   <= samp;
                            state <= ST_STOP;
                        end
                        ST_RSTART: begin
                            shreg <= {DEV_ADDR, I2C_RD};
                            state <= ST_ADDR_R;
                        end
                        ST_ACK4: begin
                            if (samp) begin
                                err   <= 1'b1;
                                state <= ST_STOP;
                            end else begin
                                state <= ST_RDATA;
                            end
                        end
                        ST_RDATA: begin
                            bit_cnt <= bit_cnt + 3'd1;
                            if (bit_cnt == 3'd7) state <= ST_MNACK;
                        end
                        ST_MNACK: state <= ST_STOP;
                        ST_STOP: begin
                            // shreg still holds the received byte: MNACK/STOP never shift.
                            if (rd_q == I2C_RD && !err) rdata <= shreg;
                            busy  <= 1'b0;
                            done  <= 1'b1;
                            state <= ST_IDLE;
                        end
                        default: state <= ST_IDLE;
                    endcase
                end
            end
        end
    end

    // Bus drive decode from state and phase; SDA only changes when a new bit's P0 begins.
    always_comb begin
        scl_lo_nxt = 1'b0;
        sda_lo_nxt = 1'b0;
        case (state)
            ST_IDLE: begin
                scl_lo_nxt = 1'b0;
                sda_lo_nxt = 1'b0;
            end
            ST_START: sda_lo_nxt = (phase == PH_3);
            ST_RSTART: begin
                scl_lo_nxt = low_half;
                sda_lo_nxt = (phase == PH_3);
            end
            ST_ADDR_W, ST_REG, ST_WDATA, ST_ADDR_R: begin
                scl_lo_nxt = low_half;
                sda_lo_nxt = ~shreg[7];
            end
            ST_STOP: begin
                scl_lo_nxt = low_half;
                sda_lo_nxt = (phase != PH_3);
            end
            default: scl_lo_nxt = low_half;
        endcase
    end

    // Registered open-drain enables keep glitches off the bus.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            scl_drv_lo <= 1'b0;
            sda_drv_lo <= 1'b0;
        end else begin
            scl_drv_lo <= scl_lo_nxt;
            sda_drv_lo <= sda_lo_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_master.sv
// Scoreboard bench for i2c_master: a clocked slave model on the bus checks
// each master-sent byte against an expected-byte queue; transaction results
// are checked when done pulses.
module tb_i2c_master;
    import i2c_pkg::*;

    localparam int CLK_DIV = 4;

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic       req = 1'b0;
    logic       rd_nwr = 1'b0;
    logic [7:0] reg_addr = 8'h00;
    logic [7:0] wdata = 8'h00;
    logic [7:0] rdata;
    logic       busy, done, err;
    logic       scl_drv_lo, sda_drv_lo;
    logic       slave_scl_lo = 1'b0;
    logic       slave_sda_lo = 1'b0;
    logic       scl_bus, sda_bus;

    assign scl_bus = !scl_drv_lo && !slave_scl_lo;
    assign sda_bus = !sda_drv_lo && !slave_sda_lo;

    i2c_master #(.CLK_DIV(CLK_DIV), .DEV_ADDR(7'h10)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .req       (req),
        .rd_nwr    (rd_nwr),
        .reg_addr  (reg_addr),
        .wdata     (wdata),
        .rdata     (rdata),
        .busy      (busy),
        .done      (done),
        .err       (err),
        .scl_in    (scl_bus),
        .sda_in    (sda_bus),
        .scl_drv_lo(scl_drv_lo),
        .sda_drv_lo(sda_drv_lo)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Scoreboard and slave model state
    logic [7:0] exp_bytes[$];
    logic       prev_scl = 1'b1, prev_sda = 1'b1;
    int         sbit = 0, byte_idx = 0;
    logic [7:0] sshift = 8'h00;
    logic       rd_mode = 1'b0, sending = 1'b0, in_txn = 1'b0;
    logic [7:0] rd_val = 8'h00;
    logic       nack_addr = 1'b0;
    logic       mack = 1'b0;
    logic       slave_clear = 1'b0;
    logic       stretch_en = 1'b0;
    int         stretch_left = 0;
    int         n_start = 0, n_rstart = 0, n_stop = 0, n_done = 0;

    always @(negedge clk) if (done) n_done++;

    // Slave model: samples on the falling clk edge so its drives are stable at DUT posedges.
    always @(negedge clk) begin
        if (slave_clear) begin
            in_txn = 1'b0; sbit = 0; byte_idx = 0; sending = 1'b0;
            slave_sda_lo = 1'b0; slave_scl_lo = 1'b0; stretch_left = 0;
        end else if (prev_scl && scl_bus && prev_sda && !sda_bus) begin
            if (in_txn) n_rstart++; else n_start++;
            in_txn = 1'b1; sbit = -1; byte_idx = 0; sending = 1'b0; rd_mode = 1'b0;
            slave_sda_lo = 1'b0;
        end else if (prev_scl && scl_bus && !prev_sda && sda_bus) begin
            n_stop++;
            in_txn = 1'b0; slave_sda_lo = 1'b0;
        end else if (in_txn && !prev_scl && scl_bus) begin
            if (sbit >= 0 && sbit < 8 && !sending) sshift = {sshift[6:0], sda_bus};
            else if (sbit == 8 && sending) mack = sda_bus;
        end else if (in_txn && prev_scl && !scl_bus) begin
            if (sbit < 7) begin
                sbit++;
                if (sending && sbit > 0) slave_sda_lo = !rd_val[7-sbit];
            end else if (sbit == 7) begin
                sbit = 8;
                if (sending) begin
                    slave_sda_lo = 1'b0;
                end else begin
                    if (exp_bytes.size() > 0) check("bus_byte", {24'd0, sshift}, {24'd0, exp_bytes.pop_front()});
                    else check("bus_byte_extra", exp_bytes.size(), 1);
                    slave_sda_lo = !(nack_addr && byte_idx == 0);
                    if (byte_idx == 0) rd_mode = sshift[0];
                    if (stretch_en && byte_idx == 1) begin
                        slave_scl_lo = 1'b1;
                        stretch_left = -1;
                    end
                end
            end else begin
                sbit = 0;
                slave_sda_lo = 1'b0;
                if (sending) begin
                    sending = 1'b0;
                end else if (rd_mode && byte_idx == 0 && !nack_addr) begin
                    sending = 1'b1;
                    slave_sda_lo = !rd_val[7];
                end
                byte_idx++;
            end
        end
        prev_scl = scl_bus;
        prev_sda = sda_bus;
        if (stretch_left < 0 && slave_scl_lo && !scl_drv_lo) begin
            stretch_left = 5 * CLK_DIV;
        end else if (stretch_left > 0) begin
            stretch_left--;
            if (stretch_left == 0) slave_scl_lo = 1'b0;
        end
    end

    task automatic pulse_req(input logic rd, input logic [7:0] ra, input logic [7:0] wd);
        @(negedge clk);
        req = 1'b1; rd_nwr = rd; reg_addr = ra; wdata = wd;
        @(negedge clk);
        req = 1'b0;
    endtask

    task automatic wait_done(output int cycles);
        cycles = 0;
        while (!done && cycles < 3000) begin
            @(negedge clk);
            cycles++;
        end
        if (!done) check("done_timeout", {31'd0, done}, 1);
    endtask

    task automatic wait_slave(input int bidx, input int sb);
        int n = 0;
        while (!(byte_idx == bidx && sbit == sb) && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("slave_pos_reached", {31'd0, (byte_idx == bidx && sbit == sb)}, 1);
    endtask

    int cyc, cyc_rd, d0, s0, st0, r0;

    initial begin
        repeat (3) @(negedge clk);
        check("rst_busy", {31'd0, busy}, 0);
        check("rst_done", {31'd0, done}, 0);
        check("rst_err", {31'd0, err}, 0);
        check("rst_rdata", {24'd0, rdata}, 32'h00);
        check("rst_scl_drv", {31'd0, scl_drv_lo}, 0);
        check("rst_sda_drv", {31'd0, sda_drv_lo}, 0);
        reset_n = 1'b1;
        repeat (2) @(negedge clk);

        // register write
        exp_bytes.push_back(8'h20); exp_bytes.push_back(8'h01); exp_bytes.push_back(8'h05);
        d0 = n_done; s0 = n_stop; st0 = n_start;
        pulse_req(I2C_WR, 8'h01, 8'h05);
        check("wr_busy", {31'd0, busy}, 1);
        wait_done(cyc);
        check("wr_err", {31'd0, err}, 0);
        check("wr_busy_at_done", {31'd0, busy}, 0);
        repeat (5) @(negedge clk);
        check("wr_done_once", n_done - d0, 1);
        check("wr_stop", n_stop - s0, 1);
        check("wr_start", n_start - st0, 1);
        check("wr_bytes_left", exp_bytes.size(), 0);
        check("idle_scl_drv", {31'd0, scl_drv_lo}, 0);
        check("idle_sda_drv", {31'd0, sda_drv_lo}, 0);

        // register read
        rd_val = 8'h10; mack = 1'b0;
        exp_bytes.push_back(8'h20); exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h21);
        d0 = n_done; r0 = n_rstart;
        pulse_req(I2C_RD, 8'h00, 8'h00);
        wait_done(cyc_rd);
        check("rd_rdata", {24'd0, rdata}, 32'h10);
        check("rd_err", {31'd0, err}, 0);
        repeat (5) @(negedge clk);
        check("rd_rstart", n_rstart - r0, 1);
        check("rd_master_nack", {31'd0, mack}, 1);
        check("rd_done_once", n_done - d0, 1);
        check("rd_bytes_left", exp_bytes.size(), 0);

        // address NACK
        nack_addr = 1'b1; rd_val = 8'h55;
        exp_bytes.push_back(8'h20);
        d0 = n_done; s0 = n_stop;
        pulse_req(I2C_RD, 8'h00, 8'h00);
        wait_done(cyc);
        check("nack_err", {31'd0, err}, 1);
        check("nack_rdata_kept", {24'd0, rdata}, 32'h10);
        repeat (5) @(negedge clk);
        check("nack_stop", n_stop - s0, 1);
        check("nack_done_once", n_done - d0, 1);
        check("nack_bytes_left", exp_bytes.size(), 0);
        nack_addr = 1'b0;

        // req while busy in REG
        exp_bytes.push_back(8'h20); exp_bytes.push_back(8'h33); exp_bytes.push_back(8'hA5);
        d0 = n_done; st0 = n_start;
        pulse_req(I2C_WR, 8'h33, 8'hA5);
        wait_slave(1, 3);
        pulse_req(I2C_RD, 8'h77, 8'h00);
        wait_done(cyc);
        check("busyreq_err_cleared", {31'd0, err}, 0);
        repeat (60) @(negedge clk);
        check("busyreq_one_start", n_start - st0, 1);
        check("busyreq_done_once", n_done - d0, 1);
        check("busyreq_idle", {31'd0, busy}, 0);
        check("busyreq_bytes_left", exp_bytes.size(), 0);

        // reset during WDATA bit 3
        exp_bytes.push_back(8'h20); exp_bytes.push_back(8'h02);
        d0 = n_done; s0 = n_stop;
        pulse_req(I2C_WR, 8'h02, 8'h3C);
        wait_slave(2, 3);
        #2 reset_n = 1'b0;
        #1;
        check("rst_mid_scl_drv", {31'd0, scl_drv_lo}, 0);
        check("rst_mid_sda_drv", {31'd0, sda_drv_lo}, 0);
        check("rst_mid_busy", {31'd0, busy}, 0);
        slave_clear = 1'b1;
        repeat (3) @(negedge clk);
        reset_n = 1'b1;
        slave_clear = 1'b0;
        repeat (40) @(negedge clk);
        check("rst_mid_no_done", n_done - d0, 0);
        check("rst_mid_no_stop", n_stop - s0, 0);
        check("rst_mid_rdata", {24'd0, rdata}, 32'h00);
        check("rst_mid_bytes_left", exp_bytes.size(), 0);

        // recovery write after reset
        exp_bytes.push_back(8'h20); exp_bytes.push_back(8'hFF); exp_bytes.push_back(8'h80);
        d0 = n_done;
        pulse_req(I2C_WR, 8'hFF, 8'h80);
        wait_done(cyc);
        check("rec_err", {31'd0, err}, 0);
        repeat (5) @(negedge clk);
        check("rec_done_once", n_done - d0, 1);
        check("rec_bytes_left", exp_bytes.size(), 0);

`ifdef I2C_MST_STRETCH_EN
        // stretched read: same bus traffic, longer by the stretch
        rd_val = 8'hA7; stretch_en = 1'b1;
        exp_bytes.push_back(8'h20); exp_bytes.push_back(8'h00); exp_bytes.push_back(8'h21);
        pulse_req(I2C_RD, 8'h00, 8'h00);
        wait_done(cyc);
        check("str_rdata", {24'd0, rdata}, 32'hA7);
        check("str_err", {31'd0, err}, 0);
        check("str_extra_cycles", cyc - cyc_rd, 5 * CLK_DIV);
        stretch_en = 1'b0;
        repeat (5) @(negedge clk);
        check("str_bytes_left", exp_bytes.size(), 0);
`endif

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
